// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter update stage.
// Branch kinds, fault FSM states and alignment/EPC constants.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BGT = 2'b10,
    BR_BLE = 2'b11
  } br_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FAULT = 1'b1
  } pc_state_e;

  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;
  localparam logic [31:0] EPC_OFFSET    = 32'd4;

endpackage

// File: rtl/pc_trace_buffer.sv
// Circular history of accepted PC targets for debug.
// Index 0 reads the newest entry; unwritten slots read as zero.
module pc_trace_buffer #(
  parameter  int DEPTH = 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] idx,
  output logic [31:0]   rdata,
  output logic [IW:0]   count
);

  localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] wptr;
  logic [IW-1:0] raddr;

  // write pointer wraps, fill count saturates at DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      count <= '0;
    end else if (we) begin
      wptr <= wptr + IW'(1);
      if (count != FULL)
        count <= count + (IW+1)'(1);
    end
  end

  // storage has no reset; the count guards stale slots
  always_ff @(posedge clk) begin
    if (we)
      mem[wptr] <= wdata;
  end

  assign raddr = wptr - IW'(1) - idx;
  assign rdata = ({1'b0, idx} < count) ? mem[raddr] : '0;

endmodule

// File: rtl/pc_update_unit.sv
// PC register stage behind the PC-source mux, with alignment fault FSM and EPC.
// Optional trace buffer built when PC_TRACE_EN is defined.
module pc_update_unit
  import pc_unit_pkg::*;
#(
  parameter  logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter  int          TRACE_DEPTH = 8,
  localparam int          IW          = $clog2(TRACE_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   pc_in,
  input  logic          pc_write,
  input  logic          pc_write_cond,
  input  logic [1:0]    branch_type,
  input  logic          alu_zero,
  input  logic          alu_gt,
  input  logic          epc_write,
  input  logic          exc_ack,
  output logic [31:0]   pc_out,
  output logic [31:0]   epc_out,
  output logic          exc_pending,
  output logic [31:0]   bad_addr,
  input  logic [IW-1:0] trace_idx,
  output logic [31:0]   trace_pc,
  output logic [IW:0]   trace_count
);

  pc_state_e   state_q, state_d;
  logic [31:0] bad_q, bad_d;
  logic        cond_met;
  logic        take;
  logic        aligned;
  logic        ok_take;
  logic        mis_take;

  // branch condition from ALU flags
  always_comb begin
    cond_met = 1'b0;
    unique case (br_type_e'(branch_type))
      BR_BEQ:  cond_met = alu_zero;
      BR_BNE:  cond_met = !alu_zero;
      BR_BGT:  cond_met = alu_gt;
      BR_BLE:  cond_met = !alu_gt;
      default: cond_met = 1'b0;
    endcase
  end

  assign take     = pc_write | (pc_write_cond & cond_met);
  assign aligned  = (pc_in[1:0] & PC_ALIGN_MASK) == 2'b00;
  assign ok_take  = take & aligned;
  assign mis_take = take & !aligned;

  // PC and EPC registers; EPC sees the pre-update PC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out  <= RESET_PC;
      epc_out <= '0;
    end else begin
      if (ok_take)
        pc_out <= pc_in;
      if (epc_write)
        epc_out <= pc_out - EPC_OFFSET;
    end
  end

  // fault FSM state and captured address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
    end
  end

  // fault next-state: first fault sticks until ack, ack+new fault re-arms
  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mis_take) begin
          state_d = ST_FAULT;
          bad_d   = pc_in;
        end
      end
      ST_FAULT: begin
        if (exc_ack) begin
          if (mis_take)
            bad_d = pc_in;
          else
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign exc_pending = (state_q == ST_FAULT);
  assign bad_addr    = bad_q;

`ifdef PC_TRACE_EN
  pc_trace_buffer #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ok_take),
    .wdata   (pc_in),
    .idx     (trace_idx),
    .rdata   (trace_pc),
    .count   (trace_count)
  );
`else
  logic unused_trace;
  assign unused_trace = ^trace_idx;
  assign trace_pc     = '0;
  assign trace_count  = '0;
`endif

endmodule
